gmii_tx_mac: RTL and testbench

Transmit MAC between `frame_sender` and the GMII PHY pins. Accepts a byte stream via the `mac_tx_dvld`/`mac_tx_ack` handshake and frames it on the wire: preamble, SFD, payload, zero padding to minimum length, CRC-32 FCS and inter-frame gap. `frame_sender` drives the `conf_*` pins; they control enable, jumbo length limit and FCS generation.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/gmii_tx_mac.sv | 184 ++++++++++++++++++
 tb/tb_gmii_tx_mac.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the GMII MAC paths: FSM encoding, framing bytes,
// CRC-32 constants and default length limits.
package eth_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_PAD      = 3'd4;
    localparam logic [2:0] ST_FCS      = 3'd5;
    localparam logic [2:0] ST_IFG      = 3'd6;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // CRC_POLY_REFL is CRC_POLY bit-reversed, used by the LSB-first datapath.
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam int MIN_DATA_DEF  = 60;
    localparam int MAX_DATA_DEF  = 1514;
    localparam int MAX_JUMBO_DEF = 9014;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected IEEE 802.3 CRC-32; pure combinational so the
// TX and RX paths can share it.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: frames the sender's byte stream with preamble, SFD, padding,
// FCS and inter-frame gap. All outputs are registered.
module gmii_tx_mac
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_DATA     = MIN_DATA_DEF,
    parameter int MAX_DATA     = MAX_DATA_DEF,
    parameter int MAX_JUMBO    = MAX_JUMBO_DEF,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       tx_clk,
    input  logic       reset_n,
    input  logic       conf_tx_en,
    input  logic       conf_tx_jumbo_en,
    input  logic       conf_tx_no_gen_crc,
    input  logic [7:0] mac_tx_data,
    input  logic       mac_tx_dvld,
    output logic       mac_tx_ack,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_frame_done,
    output logic       tx_frame_err,
    output logic [2:0] tx_state
);

    // Handshake: mac_tx_dvld is the sender's valid. mac_tx_ack pulses in the SFD
    // cycle and byte 0 is taken then; after that every cycle with mac_tx_dvld=1
    // delivers the next byte, and the first cycle with mac_tx_dvld=0 ends the frame.

    logic [2:0]  state;
    logic [13:0] cnt;
    logic [7:0]  ifg_cnt;
    logic [1:0]  fcs_idx;
    logic [31:0] crc;
    logic [31:0] crc_seed;
    logic [31:0] crc_next;
    logic [31:0] crc_fin;
    logic [7:0]  crc_in;
    logic [7:0]  fcs_byte;
    logic [13:0] max_len;
    logic [13:0] cnt_inc;
    logic        jumbo_q;
    logic        no_crc_q;
    logic        drain;

    assign tx_state = state;
    assign max_len  = jumbo_q ? 14'(MAX_JUMBO) : 14'(MAX_DATA);
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 14'd1;
    assign crc_seed = (state == ST_SFD) ? CRC_INIT : crc;
    assign crc_in   = (mac_tx_dvld && (state == ST_SFD || state == ST_DATA)) ? mac_tx_data : 8'h00;
    assign crc_fin  = ~crc;
    assign fcs_byte = crc_fin[{fcs_idx, 3'b000} +: 8];

    crc32_d8 u_crc (
        .crc      (crc_seed),
        .data     (crc_in),
        .crc_next (crc_next)
    );

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ifg_cnt       <= '0;
            fcs_idx       <= '0;
            crc           <= CRC_INIT;
            jumbo_q       <= 1'b0;
            no_crc_q      <= 1'b0;
            drain         <= 1'b0;
            gmii_txd      <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
            mac_tx_ack    <= 1'b0;
            tx_frame_done <= 1'b0;
            tx_frame_err  <= 1'b0;
        end else begin
            mac_tx_ack    <= 1'b0;
            tx_frame_done <= 1'b0;
            tx_frame_err  <= 1'b0;
            gmii_tx_er    <= 1'b0;
            if (!mac_tx_dvld) drain <= 1'b0;

            case (state)
                ST_IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (mac_tx_dvld && conf_tx_en && !drain) begin
                        state      <= ST_PREAMBLE;
                        cnt        <= 14'd1;
                        jumbo_q    <= conf_tx_jumbo_en;
                        no_crc_q   <= conf_tx_no_gen_crc;
                        gmii_txd   <= PREAMBLE_BYTE;
                        gmii_tx_en <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (cnt == 14'(PREAMBLE_LEN)) begin
                        state      <= ST_SFD;
                        gmii_txd   <= SFD_BYTE;
                        mac_tx_ack <= 1'b1;
                    end else begin
                        cnt      <= cnt_inc;
                        gmii_txd <= PREAMBLE_BYTE;
                    end
                end
                ST_SFD: begin
                    if (mac_tx_dvld) begin
                        state    <= ST_DATA;
                        gmii_txd <= mac_tx_data;
                        cnt      <= 14'd1;
                        crc      <= crc_next;
                    end else begin
                        state        <= ST_IFG;
                        ifg_cnt      <= '0;
                        gmii_txd     <= 8'h00;
                        gmii_tx_er   <= 1'b1;
                        tx_frame_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (mac_tx_dvld && cnt >= max_len) begin
                        // Oversize: poison the wire and swallow the rest of the sender's frame.
                        state        <= ST_IFG;
                        ifg_cnt      <= '0;
                        gmii_txd     <= 8'h00;
                        gmii_tx_er   <= 1'b1;
                        tx_frame_err <= 1'b1;
                        drain        <= 1'b1;
                    end else if (mac_tx_dvld) begin
                        gmii_txd <= mac_tx_data;
                        cnt      <= cnt_inc;
                        crc      <= crc_next;
                    end else if (no_crc_q) begin
                        // The last byte was already on the wire; done follows one cycle later.
                        state         <= ST_IFG;
                        ifg_cnt       <= '0;
                        gmii_txd      <= 8'h00;
                        gmii_tx_en    <= 1'b0;
                        tx_frame_done <= 1'b1;
                    end else if (cnt < 14'(MIN_DATA)) begin
                        state    <= ST_PAD;
                        gmii_txd <= 8'h00;
                        cnt      <= cnt_inc;
                        crc      <= crc_next;
                    end else begin
                        state    <= ST_FCS;
                        gmii_txd <= fcs_byte;
                        fcs_idx  <= fcs_idx + 2'd1;
                    end
                end
                ST_PAD: begin
                    if (cnt < 14'(MIN_DATA)) begin
                        gmii_txd <= 8'h00;
                        cnt      <= cnt_inc;
                        crc      <= crc_next;
                    end else begin
                        state    <= ST_FCS;
                        gmii_txd <= fcs_byte;
                        fcs_idx  <= fcs_idx + 2'd1;
                    end
                end
                ST_FCS: begin
                    gmii_txd <= fcs_byte;
                    fcs_idx  <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        state         <= ST_IFG;
                        ifg_cnt       <= '0;
                        tx_frame_done <= 1'b1;
                    end
                end
                ST_IFG: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (ifg_cnt == 8'(IFG_CYCLES - 1)) state <= ST_IDLE;
                    else ifg_cnt <= ifg_cnt + 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Randomized self-checking bench for gmii_tx_mac; the wire image of every frame is
// predicted from the framing rules and compared byte for byte.
module tb_gmii_tx_mac;
    import eth_pkg::*;

    logic       tx_clk = 1'b0;
    logic       reset_n;
    logic       conf_tx_en;
    logic       conf_tx_jumbo_en;
    logic       conf_tx_no_gen_crc;
    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_ack;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       tx_frame_done;
    logic       tx_frame_err;
    logic [2:0] tx_state;

    logic [31:0] u_crc;
    logic [7:0]  u_data;
    logic [31:0] u_next;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 tx_clk = ~tx_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, expected the run to finish");
        $fatal(1, "watchdog");
    end

    gmii_tx_mac dut (
        .tx_clk             (tx_clk),
        .reset_n            (reset_n),
        .conf_tx_en         (conf_tx_en),
        .conf_tx_jumbo_en   (conf_tx_jumbo_en),
        .conf_tx_no_gen_crc (conf_tx_no_gen_crc),
        .mac_tx_data        (mac_tx_data),
        .mac_tx_dvld        (mac_tx_dvld),
        .mac_tx_ack         (mac_tx_ack),
        .gmii_txd           (gmii_txd),
        .gmii_tx_en         (gmii_tx_en),
        .gmii_tx_er         (gmii_tx_er),
        .tx_frame_done      (tx_frame_done),
        .tx_frame_err       (tx_frame_err),
        .tx_state           (tx_state)
    );

    crc32_d8 u_crc_unit (
        .crc      (u_crc),
        .data     (u_data),
        .crc_next (u_next)
    );

    // ---------------- monitor (append-only) ----------------
    logic [7:0] obs_q[$];
    int er_cnt = 0, err_cnt = 0, done_cnt = 0, ack_cnt = 0, en_rises = 0;
    int er_pos = 0, done_pos = 0, idle_run = 1000, last_gap = 0;
    logic prev_en = 1'b0;

    always @(negedge tx_clk) begin
        if (gmii_tx_en && !prev_en) begin
            en_rises++;
            last_gap = idle_run;
        end
        if (gmii_tx_en) idle_run = 0;
        else idle_run++;
        if (gmii_tx_er) begin
            er_cnt++;
            er_pos = obs_q.size();
        end else if (gmii_tx_en) begin
            obs_q.push_back(gmii_txd);
        end
        if (mac_tx_ack) ack_cnt++;
        if (tx_frame_err) err_cnt++;
        if (tx_frame_done) begin
            done_cnt++;
            done_pos = obs_q.size();
        end
        prev_en = gmii_tx_en;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] pay[$];
    int obs_base, er_base, err_base, done_base, ack_base, rise_base;
    int exp_er, exp_err, exp_done, exp_ack, exp_rises, exp_er_pos, exp_done_pos;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic mark();
        exp_q.delete();
        obs_base  = obs_q.size();
        er_base   = er_cnt;
        err_base  = err_cnt;
        done_base = done_cnt;
        ack_base  = ack_cnt;
        rise_base = en_rises;
        exp_er = 0; exp_err = 0; exp_done = 0; exp_ack = 0; exp_rises = 0;
        exp_er_pos = 0; exp_done_pos = 0;
    endtask

    // Ethernet FCS from the textbook MSB-first shift register on LSB-first bits.
    function automatic logic [31:0] ref_fcs(input logic [7:0] body[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (body[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ body[i][b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int b = 0; b < 32; b++) r[b] = c[31 - b];
        return ~r;
    endfunction

    task automatic expect_preamble();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        exp_ack++;
        exp_rises++;
    endtask

    task automatic expect_frame(input int n, input bit crc_on, input int max_len);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        expect_preamble();
        for (int i = 0; i < n && i < max_len; i++) body.push_back(pay[i]);
        if (n > max_len) begin
            foreach (body[i]) exp_q.push_back(body[i]);
            exp_er++;
            exp_err++;
            exp_er_pos = exp_q.size();
            return;
        end
        if (crc_on) while (body.size() < 60) body.push_back(8'h00);
        foreach (body[i]) exp_q.push_back(body[i]);
        if (crc_on) begin
            fcs = ref_fcs(body);
            for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
        end
        exp_done++;
        exp_done_pos = exp_q.size();
    endtask

    task automatic expect_abort();
        expect_preamble();
        exp_er++;
        exp_err++;
        exp_er_pos = exp_q.size();
    endtask

    task automatic verify(input string tag);
        int fd;
        int n_obs;
        n_obs = obs_q.size() - obs_base;
        check_val({tag, ".len"}, 32'(n_obs), 32'(exp_q.size()));
        fd = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n_obs || obs_q[obs_base + i] !== exp_q[i]) begin
                fd = i;
                break;
            end
        end
        check_val({tag, ".first_diff"}, 32'(fd), 32'(exp_q.size()));
        check_val({tag, ".er"},   32'(er_cnt - er_base),     32'(exp_er));
        check_val({tag, ".err"},  32'(err_cnt - err_base),   32'(exp_err));
        check_val({tag, ".done"}, 32'(done_cnt - done_base), 32'(exp_done));
        check_val({tag, ".ack"},  32'(ack_cnt - ack_base),   32'(exp_ack));
        check_val({tag, ".en_runs"}, 32'(en_rises - rise_base), 32'(exp_rises));
        if (exp_er != 0) check_val({tag, ".er_pos"}, 32'(er_pos - obs_base), 32'(exp_er_pos));
        if (exp_done != 0) check_val({tag, ".done_pos"}, 32'(done_pos - obs_base), 32'(exp_done_pos));
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input int n, input int toggle_at, input bit lat_chk);
        int guard;
        @(posedge tx_clk); #1;
        mac_tx_data = pay[0];
        mac_tx_dvld = 1'b1;
        if (lat_chk) begin
            @(negedge tx_clk);
            check_val("lat.idle_cycle_en", 32'(gmii_tx_en), 32'd0);
            @(negedge tx_clk);
            check_val("lat.first_en", 32'(gmii_tx_en), 32'd1);
            check_val("lat.first_byte", 32'(gmii_txd), 32'h55);
        end
        guard = 0;
        while (!mac_tx_ack && guard < 300) begin
            @(negedge tx_clk);
            guard++;
        end
        check_val("ack_wait", 32'(mac_tx_ack), 32'd1);
        for (int k = 1; k < n; k++) begin
            @(posedge tx_clk); #1;
            mac_tx_data = pay[k];
            if (k == toggle_at) begin
                conf_tx_no_gen_crc = ~conf_tx_no_gen_crc;
                conf_tx_en = 1'b0;
            end
        end
        @(posedge tx_clk); #1;
        mac_tx_dvld = 1'b0;
        mac_tx_data = 8'h00;
    endtask

    task automatic send_abort();
        int guard;
        @(posedge tx_clk); #1;
        mac_tx_data = pay[0];
        mac_tx_dvld = 1'b1;
        guard = 0;
        while (!mac_tx_ack && guard < 300) begin
            @(negedge tx_clk);
            guard++;
        end
        check_val("abort.ack_wait", 32'(mac_tx_ack), 32'd1);
        mac_tx_dvld = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int guard = 0;
        while (quiet < 30 && guard < 20000) begin
            @(negedge tx_clk);
            guard++;
            if (!gmii_tx_en && !mac_tx_dvld) quiet++;
            else quiet = 0;
        end
        check_val("idle_reached", 32'(quiet >= 30), 32'd1);
    endtask

    task automatic set_conf(input bit crc_on, input bit jumbo);
        conf_tx_en         = 1'b1;
        conf_tx_no_gen_crc = ~crc_on;
        conf_tx_jumbo_en   = jumbo;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        string msg;
        int lens[7];
        int n;
        bit crc_on;

        reset_n = 1'b0;
        conf_tx_en = 1'b0;
        conf_tx_jumbo_en = 1'b0;
        conf_tx_no_gen_crc = 1'b0;
        mac_tx_data = 8'h00;
        mac_tx_dvld = 1'b0;
        u_crc = 32'hFFFF_FFFF;
        u_data = 8'h00;

        repeat (3) @(posedge tx_clk);
        @(negedge tx_clk);
        check_val("rst.txd",   32'(gmii_txd), 32'd0);
        check_val("rst.en",    32'(gmii_tx_en), 32'd0);
        check_val("rst.er",    32'(gmii_tx_er), 32'd0);
        check_val("rst.ack",   32'(mac_tx_ack), 32'd0);
        check_val("rst.done",  32'(tx_frame_done), 32'd0);
        check_val("rst.err",   32'(tx_frame_err), 32'd0);
        check_val("rst.state", 32'(tx_state), 32'(ST_IDLE));
        @(posedge tx_clk); #1;
        reset_n = 1'b1;

        // CRC unit: "123456789"
        msg = "123456789";
        for (int i = 0; i < 9; i++) begin
            u_data = msg[i];
            #1;
            u_crc = u_next;
        end
        check_val("crc_unit.check", ~u_crc, 32'hCBF4_3926);

        // 42-byte ARP frame with CRC
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(8'hFF);
        for (int i = 0; i < 6; i++) pay.push_back(8'($urandom_range(0, 255)));
        pay.push_back(8'h08);
        pay.push_back(8'h06);
        for (int i = 0; i < 28; i++) pay.push_back(8'($urandom_range(0, 255)));
        set_conf(1'b1, 1'b0);
        mark();
        expect_frame(42, 1'b1, MAX_DATA_DEF);
        send_frame(42, -1, 1'b1);
        wait_idle();
        verify("arp_crc");
        check_val("arp_crc.wire_cycles", 32'(obs_q.size() - obs_base), 32'd72);

        // Same frame without CRC; conf pins toggled mid-frame must not matter
        set_conf(1'b0, 1'b0);
        mark();
        expect_frame(42, 1'b0, MAX_DATA_DEF);
        send_frame(42, 20, 1'b0);
        wait_idle();
        verify("arp_nocrc");
        check_val("arp_nocrc.wire_cycles", 32'(obs_q.size() - obs_base), 32'd50);

        // Oversize without jumbo, then the same frame with jumbo
        fill_random(1600);
        set_conf(1'b1, 1'b0);
        mark();
        expect_frame(1600, 1'b1, MAX_DATA_DEF);
        send_frame(1600, -1, 1'b0);
        wait_idle();
        verify("oversize");

        set_conf(1'b1, 1'b1);
        mark();
        expect_frame(1600, 1'b1, MAX_JUMBO_DEF);
        send_frame(1600, -1, 1'b0);
        wait_idle();
        verify("jumbo");

        // Abort in the ack cycle, then a frame requested immediately
        set_conf(1'b1, 1'b0);
        mark();
        fill_random(1);
        expect_abort();
        send_abort();
        fill_random(30);
        expect_frame(30, 1'b1, MAX_DATA_DEF);
        send_frame(30, -1, 1'b0);
        wait_idle();
        verify("abort_then_frame");
        check_val("abort.gap_ge_12", 32'(last_gap >= 12), 32'd1);

        // Length boundaries around the pad threshold plus random lengths
        lens = '{1, 59, 60, 61, 0, 0, 0};
        for (int t = 0; t < 7; t++) begin
            n = (lens[t] != 0) ? lens[t] : $urandom_range(1, 120);
            crc_on = ($urandom_range(0, 3) != 0);
            fill_random(n);
            set_conf(crc_on, 1'($urandom_range(0, 1)));
            mark();
            expect_frame(n, crc_on, MAX_DATA_DEF);
            send_frame(n, -1, 1'b0);
            wait_idle();
            verify($sformatf("rand%0d_n%0d_c%0d", t, n, crc_on));
        end

        // Asynchronous reset during the FCS of a 64-byte frame
        fill_random(64);
        set_conf(1'b1, 1'b0);
        send_frame(64, -1, 1'b0);
        begin
            int guard = 0;
            while (tx_state != ST_FCS && guard < 50) begin
                @(negedge tx_clk);
                guard++;
            end
            check_val("rst_mid.reached_fcs", 32'(tx_state), 32'(ST_FCS));
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid.en",    32'(gmii_tx_en), 32'd0);
        check_val("rst_mid.txd",   32'(gmii_txd), 32'd0);
        check_val("rst_mid.er",    32'(gmii_tx_er), 32'd0);
        check_val("rst_mid.done",  32'(tx_frame_done), 32'd0);
        check_val("rst_mid.state", 32'(tx_state), 32'(ST_IDLE));
        repeat (2) @(posedge tx_clk);
        #1;
        reset_n = 1'b1;
        fill_random(20);
        mark();
        expect_frame(20, 1'b1, MAX_DATA_DEF);
        send_frame(20, -1, 1'b0);
        wait_idle();
        verify("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
